core_boot_ctrl: RTL and testbench
=================================

# core_boot_ctrl

Synthesizable boot/run controller sitting directly upstream of CoreTop. It gates the core clock enable, holds the core until the clock has settled, then issues a single-cycle first-fetch trigger with a captured boot address. It supervises execution with a retire-kicked watchdog and closes the core clock cleanly on halt or timeout. This replaces the hand-sequenced clock-gate, trigger and watchdog stimulus currently driven from the testbench.

## Interface
Parameters:
- ADDR_W, memory_pkg::MEM_ADDR_WIDTH, width of boot/first-fetch address
- SETTLE_CYCLES, 4, cycles cg_clk_en is high before the trigger (>=1)
- WATCHDOG_CYCLES, 25, consecutive RUN cycles without retire before timeout (>=2)
- DRAIN_CYCLES, 2, cycles cg_clk_en stays high after halt/timeout (>=1)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  free-running clock (ungated side of ClockGate)
- rstn  in  1  synchronous active-low reset
- start  in  1  single-cycle boot request
- boot_addr  in  ADDR_W  first fetch address, sampled with start
- retire  in  1  core heartbeat, 1 per committed instruction
- halt_req  in  1  request to stop the core
- cg_clk_en  out  1  enable to ClockGate for the core clock
- first_fetch_addr  out  ADDR_W  to CoreTop
- first_fetch_trigger  out  1  to CoreTop, single-cycle pulse
- busy  out  1  high in SETTLE, TRIGGER, RUN, DRAIN
- done  out  1  sticky, high in HALTED
- timeout  out  1  sticky, set when the watchdog expires
- state  out  3  encoded FSM state for debug

## Operation
- FSM states: IDLE, SETTLE, TRIGGER, RUN, DRAIN, HALTED.
- IDLE, or HALTED, with start: capture boot_addr into first_fetch_addr, clear done/timeout, go to SETTLE.
- start is ignored in all other states.
- SETTLE: cg_clk_en=1; a counter runs SETTLE_CYCLES cycles, then the FSM goes to TRIGGER.
- TRIGGER: first_fetch_trigger=1 for exactly one cycle, then RUN.
- RUN: the watchdog counts every cycle and clears on retire. When the count hits WATCHDOG_CYCLES-1 with no retire, set timeout and go to DRAIN. halt_req goes to DRAIN with timeout unchanged.
- DRAIN: cg_clk_en stays 1 for DRAIN_CYCLES cycles, then HALTED.
- HALTED: cg_clk_en=0, done=1, first_fetch_addr held.
- Priority in RUN, same cycle: halt_req > retire > expiry. Retire on the expiry cycle clears the count, so no timeout. halt_req on the expiry cycle gives DRAIN with timeout=0.
- halt_req outside RUN is ignored. retire outside RUN is ignored and the count is held at 0.
- Counters saturate and never wrap.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Reset values: cg_clk_en=0, first_fetch_trigger=0, first_fetch_addr=0, busy=0, done=0, timeout=0, state=IDLE.
- start sampled at edge N: cg_clk_en=1 and busy=1 from N+1. first_fetch_trigger is high for cycle N+1+SETTLE_CYCLES only.
- Watchdog: the last retire at edge M with no further retire gives timeout=1 and state=DRAIN at edge M+WATCHDOG_CYCLES. cg_clk_en falls DRAIN_CYCLES later.
- rstn low at any edge, including mid-RUN or mid-DRAIN, forces reset values at that edge. The core clock enable drops immediately.

## Configuration
- CORE_BOOT_WATCHDOG_EN defined: the watchdog behaves as above.
- Undefined: no watchdog counter. timeout is tied 0, RUN exits only on halt_req, and the retire port is unused.

## Structure
- Package core_boot_pkg holds:
  - enum boot_state_e (3-bit encoding shared with the state port)
  - default constants for settle, watchdog and drain cycles
- The watchdog is one natural sub-module, boot_watchdog (en, clear, expired), compiled only under CORE_BOOT_WATCHDOG_EN.
- The settle and drain counters share one down-counter in the top.

## Test plan
- Reset, start with boot_addr=0x100 -> cg_clk_en rises next cycle; single trigger pulse 5 cycles after start; first_fetch_addr=0x100.
- RUN with retire every 3 cycles for 100 cycles, then halt_req -> no timeout; cg_clk_en drops 2 cycles after DRAIN entry; done=1, timeout=0.
- RUN, last retire at cycle M -> timeout=1 and DRAIN at M+25; HALTED at M+27.
- Same-cycle halt_req and expiry -> timeout=0. Retire on the expiry cycle -> the core stays in RUN.
- Start in HALTED with boot_addr=0x200 -> done/timeout cleared, new trigger, address 0x200. Start during RUN is ignored.
- rstn low mid-RUN -> all outputs at reset values on that edge. Repeat the first scenario with the macro undefined -> no timeout ever after 1000 idle cycles.

Source files
------------

// File: rtl/core_boot_pkg.sv
// Shared types and defaults for the core boot/run controller.
// state encoding here is the one exported on the debug state port.
package core_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_TRIGGER = 3'd2,
    ST_RUN     = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_HALTED  = 3'd5
  } boot_state_e;

  // Stand-in for memory_pkg::MEM_ADDR_WIDTH; keep in step with the core memory map.
  localparam int BOOT_ADDR_W_DEFAULT     = 32;
  localparam int SETTLE_CYCLES_DEFAULT   = 4;
  localparam int WATCHDOG_CYCLES_DEFAULT = 25;
  localparam int DRAIN_CYCLES_DEFAULT    = 2;

endpackage

// File: rtl/core_boot_ctrl_watchdog.sv
// Retire-kicked watchdog: counts enabled cycles, saturates at CYCLES-1 and flags expiry.
// Registered count, expired decoded from the count only; no backpressure.
module boot_watchdog #(
  parameter int CYCLES = 25
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam int W = $clog2(CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || clear) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot/run controller for CoreTop: settle, one-cycle fetch trigger, run, drain, halt.
// All outputs registered (state change visible one edge after inputs); watchdog only with CORE_BOOT_WATCHDOG_EN.
module core_boot_ctrl
  import core_boot_pkg::*;
#(
  parameter int ADDR_W          = BOOT_ADDR_W_DEFAULT,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEFAULT,
  parameter int WATCHDOG_CYCLES = WATCHDOG_CYCLES_DEFAULT,
  parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic              retire,
  input  logic              halt_req,
  output logic              cg_clk_en,
  output logic [ADDR_W-1:0] first_fetch_addr,
  output logic              first_fetch_trigger,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        state
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DRAIN_CYCLES) ? SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  boot_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              timeout_q, timeout_d;
  logic              clk_en_q, trig_q, done_q;
  logic              wd_expired;

`ifdef CORE_BOOT_WATCHDOG_EN
  boot_watchdog #(
    .CYCLES (WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .en      (state_q == ST_RUN),
    .clear   (retire),
    .expired (wd_expired)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign wd_expired    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          addr_d    = boot_addr;
          timeout_d = 1'b0;
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_TRIGGER;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_TRIGGER: state_d = ST_RUN;
      ST_RUN: begin
        // halt wins over the watchdog; a retire in the same cycle suppresses expiry
        if (halt_req) begin
          cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          state_d = ST_DRAIN;
        end else if (!retire && wd_expired) begin
          timeout_d = 1'b1;
          cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      timeout_q <= 1'b0;
      clk_en_q  <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      timeout_q <= timeout_d;
      clk_en_q  <= (state_d == ST_SETTLE) || (state_d == ST_TRIGGER) ||
                   (state_d == ST_RUN)    || (state_d == ST_DRAIN);
      trig_q    <= (state_d == ST_TRIGGER);
      done_q    <= (state_d == ST_HALTED);
    end
  end

  assign cg_clk_en           = clk_en_q;
  assign busy                = clk_en_q;
  assign first_fetch_trigger = trig_q;
  assign first_fetch_addr    = addr_q;
  assign done                = done_q;
  assign state               = state_q;
`ifdef CORE_BOOT_WATCHDOG_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl with default parameters (settle 4, watchdog 25, drain 2).
module tb_core_boot_ctrl;

  localparam int AW = 32;
  localparam logic [2:0] S_IDLE = 3'd0, S_SETTLE = 3'd1, S_TRIG = 3'd2,
                         S_RUN = 3'd3, S_DRAIN = 3'd4, S_HALT = 3'd5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] boot_addr = '0;
  logic          retire = 1'b0;
  logic          halt_req = 1'b0;
  logic          cg_clk_en, first_fetch_trigger, busy, done, timeout;
  logic [AW-1:0] first_fetch_addr;
  logic [2:0]    state;

  int n_vec = 0;
  int n_err = 0;

  core_boot_ctrl dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .boot_addr           (boot_addr),
    .retire              (retire),
    .halt_req            (halt_req),
    .cg_clk_en           (cg_clk_en),
    .first_fetch_addr    (first_fetch_addr),
    .first_fetch_trigger (first_fetch_trigger),
    .busy                (busy),
    .done                (done),
    .timeout             (timeout),
    .state               (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cg"},    32'(cg_clk_en), 32'd0);
    chk({tag, ".trig"},  32'(first_fetch_trigger), 32'd0);
    chk({tag, ".addr"},  first_fetch_addr, 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd0);
    chk({tag, ".done"},  32'(done), 32'd0);
    chk({tag, ".tmo"},   32'(timeout), 32'd0);
    chk({tag, ".state"}, 32'(state), 32'(S_IDLE));
  endtask

  // Pulses start, then walks through settle; returns with the DUT just entered RUN.
  task automatic boot(input logic [AW-1:0] addr, input string tag);
    int pulses;
    boot_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".cg_rise"},   32'(cg_clk_en), 32'd1);
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    chk({tag, ".settle"},    32'(state), 32'(S_SETTLE));
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (first_fetch_trigger) pulses++;
    end
    tick();
    chk({tag, ".trig_at5"}, 32'(first_fetch_trigger), 32'd1);
    chk({tag, ".addr"},     first_fetch_addr, addr);
    tick();
    if (first_fetch_trigger) pulses++;
    chk({tag, ".extra_trig"}, 32'(pulses), 32'd0);
    chk({tag, ".run"},        32'(state), 32'(S_RUN));
  endtask

  initial begin
    #200_000;
    $display("FAIL sim_timeout: simulation did not finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int tmo_seen;
    #1;
    tick_n(2);
    chk_reset("rst");
    rstn = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'(S_IDLE));

    boot(32'h100, "boot1");

    tmo_seen = 0;
    for (int i = 0; i < 100; i++) begin
      retire = (i % 3 == 0);
      tick();
      if (timeout || state != S_RUN) tmo_seen++;
    end
    retire = 1'b0;
    chk("kick.no_exit", 32'(tmo_seen), 32'd0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt.drain", 32'(state), 32'(S_DRAIN));
    chk("halt.cg_drain", 32'(cg_clk_en), 32'd1);
    tick();
    chk("halt.cg_drain2", 32'(cg_clk_en), 32'd1);
    tick();
    chk("halt.state", 32'(state), 32'(S_HALT));
    chk("halt.cg_off", 32'(cg_clk_en), 32'd0);
    chk("halt.done", 32'(done), 32'd1);
    chk("halt.tmo", 32'(timeout), 32'd0);
    chk("halt.busy", 32'(busy), 32'd0);
    chk("halt.addr_held", first_fetch_addr, 32'h100);

    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_outside_run", 32'(state), 32'(S_HALT));

    boot(32'h200, "boot2");
    chk("boot2.done_clr", 32'(done), 32'd0);
    boot_addr = 32'h300;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run.state", 32'(state), 32'(S_RUN));
    chk("start_in_run.addr", first_fetch_addr, 32'h200);

`ifdef CORE_BOOT_WATCHDOG_EN
    retire = 1'b1;
    tick();
    retire = 1'b0;
    tick_n(24);
    chk("wd.m24_run", 32'(state), 32'(S_RUN));
    chk("wd.m24_tmo", 32'(timeout), 32'd0);
    tick();
    chk("wd.m25_tmo", 32'(timeout), 32'd1);
    chk("wd.m25_drain", 32'(state), 32'(S_DRAIN));
    tick_n(2);
    chk("wd.m27_halt", 32'(state), 32'(S_HALT));
    chk("wd.m27_cg", 32'(cg_clk_en), 32'd0);
    chk("wd.tmo_sticky", 32'(timeout), 32'd1);

    boot(32'h100, "boot3");
    chk("boot3.tmo_clr", 32'(timeout), 32'd0);
    tick_n(24);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_vs_exp.state", 32'(state), 32'(S_DRAIN));
    chk("halt_vs_exp.tmo", 32'(timeout), 32'd0);
    tick_n(2);
    chk("halt_vs_exp.done", 32'(done), 32'd1);

    boot(32'h100, "boot4");
    tick_n(24);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    chk("retire_on_exp.state", 32'(state), 32'(S_RUN));
    chk("retire_on_exp.tmo", 32'(timeout), 32'd0);
    tick_n(10);
`else
    tmo_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (timeout || state != S_RUN) tmo_seen++;
    end
    chk("nowd.no_timeout", 32'(tmo_seen), 32'd0);
`endif

    chk("pre_rst.cg", 32'(cg_clk_en), 32'd1);
    rstn = 1'b0;
    tick();
    chk_reset("rst_mid_run");
    rstn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
